xdma_write_req_arbiter: RTL
===========================

Name: xdma_write_req_arbiter

Overview:
- Shares the single xDMA write-request reshaper between NumReq requesters, e.g. ToRemoteData and ToRemoteCfg sources.
- Round-robin arbitration among eligible requesters.
- Registers the winning descriptor and holds it stable for the whole transfer.
- Issues a one-cycle launch pulse to the reshaper, then locks the grant until the W channel reports transfer done.
- Returns per-requester accept and done pulses.

Parameters:
- NumReq, 3, number of requesters (2..8).
- xdma_req_desc_t, logic, descriptor struct {dma_id, dma_type, remote_addr, dma_length, ready_to_transfer}.
- xdma_req_idx_t, logic, requester index type driven to the reshaper; requester i maps to index value i.
- TimeoutCycles, 4096, watchdog limit in WAIT_DONE; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_desc_i  in  NumReq x $bits(xdma_req_desc_t)  per-requester descriptor.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  one-hot accept pulse.
- req_done_o  out  NumReq  one-hot completion pulse.
- write_req_desc_o  out  $bits(xdma_req_desc_t)  held descriptor to the reshaper.
- write_req_idx_o  out  $bits(xdma_req_idx_t)  granted requester index.
- write_req_desc_valid_o  out  1  one-cycle launch pulse to the reshaper.
- write_req_done_i  in  1  transfer complete, from the W channel; also fed to the reshaper.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_i high at a clock edge) puts the block in IDLE:
  - all outputs 0, held descriptor 0, round-robin pointer 0;
  - applies mid-transfer as well: any lock is dropped and no done pulse is issued.
- Eligibility: requester i is eligible when req_valid_i[i] && req_desc_i[i].ready_to_transfer && req_desc_i[i].dma_length != 0.
- Requester rules:
  - a requester holds valid and its descriptor stable until req_ready_o[i];
  - withdrawing valid before the grant is legal and produces no grant.
- FSM states: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - if any requester is eligible, select the first one at or after the pointer, scanning upward with wrap-around;
  - at the clock edge: register its descriptor and index, pulse req_ready_o[i] high for this same (combinational) cycle, set pointer to (i+1) mod NumReq, go to LAUNCH.
- LAUNCH:
  - write_req_desc_valid_o=1 for exactly one cycle (first cycle after the accept), then go to WAIT_DONE;
  - write_req_done_i in this cycle is ignored.
- WAIT_DONE:
  - write_req_desc_o and write_req_idx_o stay constant;
  - on write_req_done_i: req_done_o[idx]=1 for one cycle (registered, in the cycle after done_i is sampled), go to IDLE.
  - a new grant is possible in the same cycle the done pulse is visible (earliest: accept at t, launch at t+1, done_i at t+k, done_o and next accept at t+k+1).
- write_req_done_i in IDLE is ignored.
- Requests arriving during LAUNCH or WAIT_DONE wait; arbitration uses their state when IDLE is re-entered.
- At most one requester is ever granted; req_ready_o and req_done_o are one-hot or zero.
- NumReq not a power of two: pointer wraps at NumReq-1 to 0, never reaches an invalid index.

Optional Feature:
- XDMA_WR_ARB_TIMEOUT_EN defined:
  - adds a $clog2(TimeoutCycles+1)-bit counter, cleared on entering WAIT_DONE, incremented each WAIT_DONE cycle;
  - when it reaches TimeoutCycles with no done: pulse timeout_o (extra 1-bit output) for one cycle, issue no req_done_o, go to IDLE.
- Undefined: no counter and no timeout_o port; WAIT_DONE waits indefinitely.

Decomposition:
- Add to xdma_pkg:
  - xdma_req_idx_t and the requester enumerations (ToRemoteData, ToRemoteCfg, ...);
  - xdma_req_desc_t;
  - localparam XdmaWrArbNumReq.
- Sub-module xdma_rr_pick: combinational round-robin picker (inputs: eligible vector, pointer; outputs: grant index, any-valid). Reusable by the read side.

Test Plan:
- Single request, idx 0, dma_length=130, ready_to_transfer=1:
  - ready_o[0] at cycle t, desc_valid_o only at t+1, desc stable;
  - done_i at t+20 -> done_o[0] at t+21, busy_o drops.
- Requesters 0, 1 and 2 all valid continuously, done_i 5 cycles after each launch -> grant order 0,1,2,0; never two outstanding.
- Requester 1 valid with ready_to_transfer=0, requester 2 eligible -> requester 2 granted; 1 is granted only after its flag rises.
- Grant, then rst_i high during WAIT_DONE -> next cycle all outputs 0 and pointer 0; later done_i produces no done_o.
- done_i pulsed in IDLE and in LAUNCH -> no state change and no done_o.
- With XDMA_WR_ARB_TIMEOUT_EN and TimeoutCycles=16, no done_i -> timeout_o exactly 16 cycles after entering WAIT_DONE, return to IDLE, no done_o.

Source files
------------

// File: rtl/xdma_pkg.sv
// Shared xDMA types: requester indices, request descriptor and write-arbiter state encoding.
package xdma_pkg;

    localparam int unsigned XdmaWrArbNumReq = 3;
    localparam int unsigned XdmaReqIdxW     = 3;

    typedef logic [XdmaReqIdxW-1:0] xdma_req_idx_t;

    typedef enum logic [XdmaReqIdxW-1:0] {
        ToRemoteData   = 3'd0,
        ToRemoteCfg    = 3'd1,
        ToRemoteFinish = 3'd2
    } xdma_requester_e;

    typedef struct packed {
        logic [7:0]  dma_id;
        logic [1:0]  dma_type;
        logic [31:0] remote_addr;
        logic [15:0] dma_length;
        logic        ready_to_transfer;
    } xdma_req_desc_t;

    typedef enum logic [1:0] {
        WR_ARB_IDLE,
        WR_ARB_LAUNCH,
        WR_ARB_WAIT_DONE
    } xdma_wr_arb_state_e;

endpackage

// File: rtl/xdma_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i, wrapping at NumReq-1.
module xdma_rr_pick #(
    parameter  int unsigned NumReq = 3,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] eligible_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   grant_idx_o,
    output logic              any_valid_o
);

    // Scan from the farthest offset down so the closest eligible index is written last.
    always_comb begin
        grant_idx_o = '0;
        any_valid_o = |eligible_i;
        for (int unsigned off = NumReq; off > 0; off--) begin
            int unsigned     cand;
            logic [IdxW-1:0] cand_idx;
            cand = 32'(ptr_i) + off - 1;
            if (cand >= NumReq) cand = cand - NumReq;
            cand_idx = IdxW'(cand);
            if (eligible_i[cand_idx]) grant_idx_o = cand_idx;
        end
    end

endmodule

// File: rtl/xdma_write_req_arbiter.sv
// Round-robin arbiter sharing the xDMA write-request reshaper; grant is locked until the W channel reports done.
// Optional watchdog in WAIT_DONE (adds timeout_o) is enabled by defining XDMA_WR_ARB_TIMEOUT_EN.
module xdma_write_req_arbiter
    import xdma_pkg::*;
#(
    parameter  int unsigned NumReq        = XdmaWrArbNumReq,
`ifdef XDMA_WR_ARB_TIMEOUT_EN
    parameter  int unsigned TimeoutCycles = 4096,
`endif
    localparam int unsigned IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  xdma_req_desc_t [NumReq-1:0]      req_desc_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    output logic [NumReq-1:0]                req_done_o,
    output xdma_req_desc_t                   write_req_desc_o,
    output xdma_req_idx_t                    write_req_idx_o,
    output logic                             write_req_desc_valid_o,
    input  logic                             write_req_done_i,
    output logic                             busy_o
`ifdef XDMA_WR_ARB_TIMEOUT_EN
    ,
    output logic                             timeout_o
`endif
);

    xdma_wr_arb_state_e state_q, state_d;

    logic [NumReq-1:0] eligible;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   grant_idx;
    logic              any_elig;
    logic              accept;
    logic              done_hit;

    xdma_req_desc_t    desc_q;
    xdma_req_idx_t     idx_q;
    logic [NumReq-1:0] done_q;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && req_desc_i[i].ready_to_transfer
                          && (req_desc_i[i].dma_length != '0);
        end
    end

    xdma_rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .grant_idx_o (grant_idx),
        .any_valid_o (any_elig)
    );

    assign accept   = (state_q == WR_ARB_IDLE) && any_elig && !rst_i;
    assign done_hit = (state_q == WR_ARB_WAIT_DONE) && write_req_done_i;

`ifdef XDMA_WR_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;
    logic            timeout_hit;

    // Counter holds k during the (k+1)-th WAIT_DONE cycle, so the pulse lands TimeoutCycles cycles after entry.
    assign timeout_hit = (state_q == WR_ARB_WAIT_DONE) && !write_req_done_i
                         && (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state_q == WR_ARB_LAUNCH) begin
                cnt_q <= '0;
            end else if (state_q == WR_ARB_WAIT_DONE) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign timeout_o = timeout_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WR_ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WR_ARB_IDLE:      if (any_elig) state_d = WR_ARB_LAUNCH;
            WR_ARB_LAUNCH:    state_d = WR_ARB_WAIT_DONE;
            WR_ARB_WAIT_DONE: begin
                if (write_req_done_i) state_d = WR_ARB_IDLE;
`ifdef XDMA_WR_ARB_TIMEOUT_EN
                else if (timeout_hit) state_d = WR_ARB_IDLE;
`endif
            end
            default:          state_d = WR_ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_ready_o[i] = accept && (grant_idx == IdxW'(i));
        end
        write_req_desc_valid_o = (state_q == WR_ARB_LAUNCH);
        busy_o                 = (state_q != WR_ARB_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            desc_q <= '0;
            idx_q  <= '0;
            done_q <= '0;
        end else begin
            done_q <= '0;
            if (accept) begin
                desc_q <= req_desc_i[grant_idx];
                idx_q  <= XdmaReqIdxW'(grant_idx);
                ptr_q  <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);
            end
            if (done_hit) begin
                for (int unsigned i = 0; i < NumReq; i++) begin
                    done_q[i] <= (idx_q == XdmaReqIdxW'(i));
                end
            end
        end
    end

    assign write_req_desc_o = desc_q;
    assign write_req_idx_o  = idx_q;
    assign req_done_o       = done_q;

endmodule
